udp_tx_buf: RTL and testbench

Video-to-UDP transmit packer: accepts a 16-bit video stream (vid_vs/vid_de/vid_data), prefixes each frame with the 32-bit frame head and emits byte-wide UDP payload packets to the UDP stack's app_tx_* interface. It is the transmit-side counterpart of the UDP receive buffer. Frames it produces are re-assembled by that buffer on the far end: head match, then byte pairs MSB-first. It sits between the video source and udp_top, in the 125 MHz UDP application clock domain.

---
 rtl/udp_pkg.sv | 18 +
 rtl/udp_tx_fifo.sv | 58 +++++
 rtl/udp_tx_buf.sv | 160 ++++++++++++++++
 tb/tb_udp_tx_buf.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// Shared UDP application-side definitions: frame marker, transmit FSM states
// and the common length/byte/word widths used on both TX and RX paths.
package udp_pkg;

  localparam logic [31:0] FRAME_HEAD_DEF = 32'hF3ED_7A93;

  localparam int LEN_W  = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_SEND,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/udp_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of 16-bit words with full/count status.
// Pushes while full and pops while empty are ignored.
module udp_tx_fifo
  import udp_pkg::*;
#(
  parameter int DEPTH = 2048
) (
  input  logic                       app_rx_clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WORD_W-1:0]          din,
  input  logic                       pop,
  output logic [WORD_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign dout  = mem[rd_ptr];

  // NOTE: the storage array has no reset; emptiness is defined by the pointers
  // and count alone, which keeps the array mappable onto block RAM.
  always_ff @(posedge app_rx_clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples pre-edge values, independent of statement order.
  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/udp_tx_buf.sv
// Video-to-UDP transmit packer: frame head + 16-bit pixels -> byte-wide UDP payload.
// Define UDP_TX_FLUSH_EN to flush partial packets after FLUSH_TIMEOUT idle cycles.
module udp_tx_buf
  import udp_pkg::*;
#(
  parameter logic [31:0] FRAME_HEAD    = FRAME_HEAD_DEF,
  parameter int          PKT_LEN       = 1024,
  parameter int          FIFO_DEPTH    = 2048,
  parameter int          FLUSH_TIMEOUT = 256,
  parameter int          IPG_CYCLES    = 12
) (
  input  logic              app_rx_clk,
  input  logic              rstn,
  input  logic              vid_vs,
  input  logic              vid_de,
  input  logic [WORD_W-1:0] vid_data,
  input  logic              udp_tx_ready,
  input  logic              app_tx_ack,
  output logic              app_tx_data_request,
  output logic              app_tx_data_valid,
  output logic [BYTE_W-1:0] app_tx_data,
  output logic [LEN_W-1:0]  app_tx_data_length,
  output logic              tx_overflow
);

  localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] HALF_LEN = LEN_W'(PKT_LEN / 2);

  logic              vid_vs_q;
  logic              head_lo_q;
  logic              vs_rise;
  logic              push_req;
  logic [WORD_W-1:0] push_data;
  logic              drop;
  logic              fifo_pop;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [LEN_W-1:0]  count_w;
  logic [LEN_W-1:0]  avail_words;
  logic              flush;
  logic              start;
  tx_state_t         state;
  logic [LEN_W-1:0]  byte_idx;
  logic [LEN_W-1:0]  gap_cnt;

  assign vs_rise = vid_vs & ~vid_vs_q;

  // NOTE: every always_comb output gets a default first so no path can hold
  // a previous value and infer a latch.
  always_comb begin
    push_req  = vs_rise | head_lo_q | vid_de;
    push_data = vid_data;
    if (vs_rise)        push_data = FRAME_HEAD[31:16];
    else if (head_lo_q) push_data = FRAME_HEAD[15:0];
    drop = (vid_de & (vs_rise | head_lo_q)) | (push_req & fifo_full);
  end

  // A new frame clears the sticky flag even if its own first word is dropped.
  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      vid_vs_q    <= 1'b0;
      head_lo_q   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      vid_vs_q  <= vid_vs;
      head_lo_q <= vs_rise;
      if (vs_rise)   tx_overflow <= 1'b0;
      else if (drop) tx_overflow <= 1'b1;
    end
  end

  udp_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .app_rx_clk (app_rx_clk),
    .rstn       (rstn),
    .push       (push_req),
    .din        (push_data),
    .pop        (fifo_pop),
    .dout       (fifo_dout),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

`ifdef UDP_TX_FLUSH_EN
  logic [LEN_W-1:0] idle_cnt;

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if ((push_req && !fifo_full) || fifo_empty) begin
      idle_cnt <= '0;
    end else if (idle_cnt != LEN_W'(FLUSH_TIMEOUT)) begin
      idle_cnt <= idle_cnt + LEN_W'(1);
    end
  end

  assign flush = !fifo_empty && (idle_cnt == LEN_W'(FLUSH_TIMEOUT));
`else
  assign flush = 1'b0;
`endif

  assign count_w     = LEN_W'(fifo_count);
  assign avail_words = (count_w >= HALF_LEN) ? HALF_LEN : count_w;
  assign start       = udp_tx_ready && !fifo_empty && ((count_w >= HALF_LEN) || flush);
  // The word is consumed at the edge that presents its low byte.
  assign fifo_pop    = (state == ST_SEND) && !byte_idx[0];

  always_ff @(posedge app_rx_clk or negedge rstn) begin
    if (!rstn) begin
      state               <= ST_IDLE;
      app_tx_data_request <= 1'b0;
      app_tx_data_valid   <= 1'b0;
      app_tx_data         <= '0;
      app_tx_data_length  <= '0;
      byte_idx            <= '0;
      gap_cnt             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            app_tx_data_length  <= avail_words << 1;
            app_tx_data_request <= 1'b1;
            state               <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (app_tx_ack) begin
            app_tx_data_request <= 1'b0;
            app_tx_data_valid   <= 1'b1;
            app_tx_data         <= fifo_dout[15:8];
            byte_idx            <= '0;
            state               <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!byte_idx[0]) begin
            app_tx_data <= fifo_dout[7:0];
            byte_idx    <= byte_idx + LEN_W'(1);
          end else if (byte_idx == app_tx_data_length - LEN_W'(1)) begin
            app_tx_data_valid <= 1'b0;
            app_tx_data       <= '0;
            gap_cnt           <= '0;
            state             <= ST_GAP;
          end else begin
            app_tx_data <= fifo_dout[15:8];
            byte_idx    <= byte_idx + LEN_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == LEN_W'(IPG_CYCLES - 1)) state <= ST_IDLE;
          else                                   gap_cnt <= gap_cnt + LEN_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_buf.sv
// Directed bench for udp_tx_buf: reset, full packet, flush/no-flush residue,
// delayed ack, FIFO overflow on a 16-deep instance and inter-packet gap.
module tb_udp_tx_buf;

  localparam logic [31:0] FH  = 32'hF3ED_7A93;
  localparam int          IPG = 12;

  logic        clk;
  logic        rstn;
  logic        vid_vs, vid_de, udp_tx_ready, app_tx_ack;
  logic [15:0] vid_data;
  logic        app_tx_data_request, app_tx_data_valid, tx_overflow;
  logic [7:0]  app_tx_data;
  logic [15:0] app_tx_data_length;

  logic        s_vs, s_de;
  logic [15:0] s_data;
  logic        s_req, s_valid, s_overflow;
  logic [7:0]  s_byte;
  logic [15:0] s_len;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          last_push_cyc;
  logic [15:0] exp_q[$];

  udp_tx_buf dut (
    .app_rx_clk          (clk),
    .rstn                (rstn),
    .vid_vs              (vid_vs),
    .vid_de              (vid_de),
    .vid_data            (vid_data),
    .udp_tx_ready        (udp_tx_ready),
    .app_tx_ack          (app_tx_ack),
    .app_tx_data_request (app_tx_data_request),
    .app_tx_data_valid   (app_tx_data_valid),
    .app_tx_data         (app_tx_data),
    .app_tx_data_length  (app_tx_data_length),
    .tx_overflow         (tx_overflow)
  );

  udp_tx_buf #(.FIFO_DEPTH(16)) dut_s (
    .app_rx_clk          (clk),
    .rstn                (rstn),
    .vid_vs              (s_vs),
    .vid_de              (s_de),
    .vid_data            (s_data),
    .udp_tx_ready        (1'b0),
    .app_tx_ack          (1'b0),
    .app_tx_data_request (s_req),
    .app_tx_data_valid   (s_valid),
    .app_tx_data         (s_byte),
    .app_tx_data_length  (s_len),
    .tx_overflow         (s_overflow)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on the main instance and records the words it should emit.
  task automatic send_frame(input int n, input logic [15:0] base, input bit collide);
    vid_vs = 1'b1;
    exp_q.push_back(FH[31:16]);
    tick();
    exp_q.push_back(FH[15:0]);
    vid_de   = collide;
    vid_data = 16'hDEAD;
    tick();
    for (int i = 0; i < n; i++) begin
      vid_de   = 1'b1;
      vid_data = 16'(base + i);
      exp_q.push_back(16'(base + i));
      tick();
    end
    vid_de        = 1'b0;
    vid_vs        = 1'b0;
    last_push_cyc = cyc;
  endtask

  task automatic recv_pkt(input int ack_delay, input int exp_len, input string name,
                          output int req_cyc, output int last_cyc);
    int n, held, vbad, bad, vrun, bad_idx;
    logic [15:0] w;
    logic [7:0]  eb, bad_got, bad_exp;
    req_cyc  = 0;
    last_cyc = 0;
    n = 0;
    while (app_tx_data_request !== 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    check({name, "_req_seen"}, 32'(app_tx_data_request), 1);
    if (app_tx_data_request !== 1'b1) return;
    req_cyc = cyc;
    check({name, "_length"}, 32'(app_tx_data_length), exp_len);
    held = 0;
    vbad = 0;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      if (app_tx_data_request === 1'b1) held++;
      if (app_tx_data_valid !== 1'b0 || app_tx_data !== 8'h00 ||
          app_tx_data_length !== 16'(exp_len)) vbad++;
    end
    if (ack_delay > 0) begin
      check({name, "_req_held"}, held, ack_delay);
      check({name, "_quiet_before_ack"}, vbad, 0);
    end
    app_tx_ack = 1'b1;
    tick();
    app_tx_ack = 1'b0;
    check({name, "_first_valid"}, 32'(app_tx_data_valid), 1);
    bad = 0; vrun = 0; bad_idx = 0; bad_got = 0; bad_exp = 0; w = 0;
    for (int i = 0; i < exp_len; i++) begin
      if (i % 2 == 0) begin
        if (exp_q.size() > 0) w = exp_q.pop_front();
        else                  w = 16'hxxxx;
      end
      eb = (i % 2 == 1) ? w[7:0] : w[15:8];
      if (app_tx_data_valid === 1'b1) vrun++;
      if (app_tx_data !== eb || app_tx_data_length !== 16'(exp_len)) begin
        if (bad == 0) begin
          bad_idx = i;
          bad_got = app_tx_data;
          bad_exp = eb;
        end
        bad++;
      end
      last_cyc = cyc;
      tick();
    end
    check({name, "_valid_run"}, vrun, exp_len);
    check($sformatf("%s_bad_bytes(first idx %0d got %0h want %0h)", name, bad_idx,
                    bad_got, bad_exp), bad, 0);
    check({name, "_valid_end"}, 32'(app_tx_data_valid), 0);
    check({name, "_data_idle"}, 32'(app_tx_data), 0);
  endtask

  initial begin
    int req_cnt, r0, l0, r1, l1, r2, l2;

    rstn = 1'b0;
    app_tx_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vid_vs       = 1'($urandom);
      vid_de       = 1'($urandom);
      vid_data     = 16'($urandom);
      udp_tx_ready = 1'($urandom);
      app_tx_ack   = 1'($urandom);
      s_vs         = 1'($urandom);
      s_de         = 1'($urandom);
      s_data       = 16'($urandom);
      tick();
    end
    check("rst_request", 32'(app_tx_data_request), 0);
    check("rst_valid", 32'(app_tx_data_valid), 0);
    check("rst_data", 32'(app_tx_data), 0);
    check("rst_length", 32'(app_tx_data_length), 0);
    check("rst_overflow", 32'(tx_overflow), 0);
    check("rst_s_overflow", 32'(s_overflow), 0);
    check("rst_s_request", 32'(s_req), 0);

    vid_vs = 1'b0; vid_de = 1'b0; udp_tx_ready = 1'b1; app_tx_ack = 1'b0;
    s_vs = 1'b0; s_de = 1'b0; s_data = 16'h0;
    rstn = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      app_tx_ack = 1'($urandom);
      vid_data   = 16'($urandom);
      tick();
      if (app_tx_data_request !== 1'b0 || app_tx_data_valid !== 1'b0) req_cnt++;
    end
    app_tx_ack = 1'b0;
    check("post_rst_no_request", req_cnt, 0);

    // Overflow on the 16-deep instance: 2 head words + 14 pixels fit.
    s_vs = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      s_de   = 1'b1;
      s_data = 16'(i + 1);
      tick();
      if (i == 13) check("ovf_not_yet", 32'(s_overflow), 0);
    end
    s_de = 1'b0;
    check("ovf_set", 32'(s_overflow), 1);
    check("ovf_count", 32'(dut_s.u_fifo.count), 16);
    s_vs = 1'b0;
    tick();
    s_vs = 1'b1;
    tick();
    check("ovf_cleared_by_vs", 32'(s_overflow), 0);
    tick();
    check("ovf_head_lo_dropped", 32'(s_overflow), 1);
    check("ovf_count_held", 32'(dut_s.u_fifo.count), 16);
    check("ovf_no_request", 32'(s_req), 0);
    s_vs = 1'b0;

    // One full packet: head + pixels 0x0001..0x01FE, ack right after request.
    fork
      send_frame(510, 16'h0001, 1'b0);
      recv_pkt(0, 1024, "main", r0, l0);
    join
    check("main_fifo_drained", exp_q.size(), 0);
    check("main_no_overflow", 32'(tx_overflow), 0);

    // Short frame with a pixel colliding with the head; residue handling.
    tick();
    send_frame(3, 16'h0A00, 1'b1);
    check("collide_overflow", 32'(tx_overflow), 1);
`ifdef UDP_TX_FLUSH_EN
    recv_pkt(0, 10, "flush", r0, l0);
    check("flush_delay", r0 - last_push_cyc, 257);
    check("flush_fifo_drained", exp_q.size(), 0);
`else
    req_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (app_tx_data_request !== 1'b0) req_cnt++;
    end
    check("noflush_no_request", req_cnt, 0);
`endif

    // Two back-to-back full packets, first ack delayed by 20 cycles.
    fork
      send_frame(1022, 16'h1000, 1'b0);
      begin
        recv_pkt(20, 1024, "p1", r1, l1);
        recv_pkt(0, 1024, "p2", r2, l2);
      end
    join
    check("ipg_respected", 32'((r2 - l1) >= IPG), 1);
    check("b2b_overflow_cleared", 32'(tx_overflow), 0);
`ifdef UDP_TX_FLUSH_EN
    check("b2b_residue", exp_q.size(), 0);
`else
    check("b2b_residue", exp_q.size(), 5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
